// File: rtl/nco_sweep_pkg.sv
// Shared types and default sizes for the NCO sweep controller.
// Used by nco_sweep_ctrl and its tag delay lines.
package nco_sweep_pkg;

  localparam int APR_DEF     = 32;
  localparam int CW_DEF      = 16;
  localparam int NCO_LAT_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/nco_tag_dly.sv
// Tag delay line that tracks samples through the NCO pipeline.
// Shifts only on enabled cycles; synchronous clear wins over shift.
module nco_tag_dly #(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic tail
);

  logic [DEPTH-1:0] q;

  // shift register advancing once per NCO clock-enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        q[i] <= q[i-1];
      end
    end
  end

  assign tail = q[DEPTH-1];

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency sweep sequencer for a single-channel NCO.
// Define NCO_SWEEP_LOOP_EN to repeat the sweep until abort.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int APR     = APR_DEF,
  parameter int CW      = CW_DEF,
  parameter int NCO_LAT = NCO_LAT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [APR-1:0] cfg_start_inc,
  input  logic [APR-1:0] cfg_step,
  input  logic [CW-1:0]  cfg_nsteps,
  input  logic [CW-1:0]  cfg_dwell,
  input  logic           start,
  input  logic           abort,
  input  logic           nco_valid_i,
  output logic [APR-1:0] phi_inc_o,
  output logic           nco_clken_o,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  step_idx,
  output logic           mark_o,
  output logic           smp_valid_o
);

  state_e         state_q;
  state_e         state_d;
  logic [APR-1:0] sh_step;
  logic [CW-1:0]  sh_nsteps;
  logic [CW-1:0]  sh_dwell;
  logic [CW-1:0]  dwell_cnt;
  logic [CW-1:0]  drain_cnt;
`ifdef NCO_SWEEP_LOOP_EN
  logic [APR-1:0] sh_start_inc;
`endif

  logic start_ok;
  logic abort_ok;
  logic dwell_last;
  logic step_last;
  logic mark_in;
  logic val_in;
  logic tag_clr;
  logic mark_tail;
  logic val_tail;

  assign start_ok   = (state_q == IDLE) && start && !abort;
  assign abort_ok   = (state_q != IDLE) && abort;
  assign dwell_last = (dwell_cnt == CW'(1));
  assign step_last  = (step_idx == sh_nsteps - CW'(1));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state; abort overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = (cfg_nsteps == '0) ? DONE : DWELL;
        end
      end
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dwell_last && step_last) begin
`ifdef NCO_SWEEP_LOOP_EN
          state_d = DWELL;
`else
          state_d = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (drain_cnt == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // shadow config, increment, step and dwell/drain counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_step   <= '0;
      sh_nsteps <= '0;
      sh_dwell  <= '0;
      dwell_cnt <= '0;
      drain_cnt <= '0;
      phi_inc_o <= '0;
      step_idx  <= '0;
`ifdef NCO_SWEEP_LOOP_EN
      sh_start_inc <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            sh_step   <= cfg_step;
            sh_nsteps <= cfg_nsteps;
            sh_dwell  <= (cfg_dwell == '0) ? CW'(1) : cfg_dwell;
`ifdef NCO_SWEEP_LOOP_EN
            sh_start_inc <= cfg_start_inc;
`endif
            if (cfg_nsteps != '0) begin
              phi_inc_o <= cfg_start_inc;
              step_idx  <= '0;
              dwell_cnt <= (cfg_dwell == '0) ? CW'(1) : cfg_dwell;
            end
          end
        end
        DWELL: begin
          if (!abort) begin
            dwell_cnt <= dwell_cnt - CW'(1);
            if (dwell_last && step_last) begin
`ifdef NCO_SWEEP_LOOP_EN
              phi_inc_o <= sh_start_inc;
              step_idx  <= '0;
              dwell_cnt <= sh_dwell;
`else
              drain_cnt <= CW'(NCO_LAT);
`endif
            end else if (dwell_last) begin
              phi_inc_o <= phi_inc_o + sh_step;
              step_idx  <= step_idx + CW'(1);
              dwell_cnt <= sh_dwell;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - CW'(1);
        end
        DONE: begin
        end
      endcase
    end
  end

  assign busy        = (state_q == DWELL) || (state_q == DRAIN);
  assign nco_clken_o = busy;
  assign done        = (state_q == DONE);

  assign mark_in = (state_q == DWELL) && (dwell_cnt == sh_dwell);
  assign val_in  = (state_q == DWELL);
  assign tag_clr = abort_ok || start_ok;

  nco_tag_dly #(.DEPTH(NCO_LAT)) u_mark_dly (
    .clk  (clk),
    .rst  (reset),
    .en   (nco_clken_o),
    .clr  (tag_clr),
    .din  (mark_in),
    .tail (mark_tail)
  );

  nco_tag_dly #(.DEPTH(NCO_LAT)) u_val_dly (
    .clk  (clk),
    .rst  (reset),
    .en   (nco_clken_o),
    .clr  (tag_clr),
    .din  (val_in),
    .tail (val_tail)
  );

  assign mark_o      = mark_tail & nco_valid_i;
  assign smp_valid_o = val_tail & nco_valid_i;

endmodule
